// File: rtl/qformat_pkg.sv
// Shared Q-format definitions for the Kalman datapath multiplier and divider:
// word geometry, saturation constants and the divider FSM states.
package qformat_pkg;

  localparam int N     = 32;
  localparam int Q     = 18;
  localparam int NQ    = N + Q;
  localparam int CNT_W = $clog2(NQ + 1);

  localparam logic [N-1:0] QMAX = 32'h7FFF_FFFF;
  localparam logic [N-1:0] QMIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  // Magnitude as an unsigned word; the most negative value maps onto 2^(N-1).
  function automatic logic [N-1:0] q_abs(input logic [N-1:0] v);
    return v[N-1] ? (~v + N'(1)) : v;
  endfunction

endpackage

// File: rtl/qdiv_step.sv
// One restoring-division step: shift a numerator bit into the remainder and
// subtract the divisor whenever it fits.
module qdiv_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem_in,
  input  logic [W-1:0] divisor,
  input  logic         num_bit,
  output logic [W:0]   rem_out,
  output logic         q_bit
);

  logic [W+1:0] shifted;

  // The difference is always below the divisor, so W+1 bits hold it exactly.
  always_comb begin
    shifted = {rem_in, num_bit};
    q_bit   = (shifted >= {2'b00, divisor});
    rem_out = q_bit ? (shifted[W:0] - {1'b0, divisor}) : shifted[W:0];
  end

endmodule

// File: rtl/qdiv_iter.sv
// Sequential signed Q-format divider, one quotient bit per clock, with
// truncation toward zero and saturation on overflow or divide-by-zero.
module qdiv_iter
  import qformat_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_result,
  output logic         o_ovr,
  output logic         o_div_zero
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [N:0]       rem;
  logic [N:0]       rem_nxt;
  logic [NQ-1:0]    numer;
  logic [NQ-1:0]    quo;
  logic [N-1:0]     mag_b;
  logic             sign_q;
  logic             a_neg_q;
  logic             dz_q;
  logic             q_bit;
  logic [N-1:0]     res_nxt;
  logic             ovr_nxt;

  qdiv_step #(.W(N)) u_step (
    .rem_in  (rem),
    .divisor (mag_b),
    .num_bit (numer[NQ-1]),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // A zero divisor still spends one cycle in CALC so that done arrives two
  // cycles after the accepting edge.
  always_comb begin
    state_nxt = state;
    o_busy    = (state != IDLE);
    unique case (state)
      IDLE: if (i_start) state_nxt = CALC;
      CALC: if (dz_q || (cnt == CNT_W'(1))) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    res_nxt = '0;
    ovr_nxt = 1'b0;
    if (dz_q) begin
      res_nxt = a_neg_q ? QMIN : QMAX;
      ovr_nxt = 1'b1;
    end else if (|quo[NQ-1:N-1]) begin
      res_nxt = sign_q ? QMIN : QMAX;
      ovr_nxt = 1'b1;
    end else if (quo == '0) begin
      res_nxt = '0;
    end else begin
      res_nxt = sign_q ? (~quo[N-1:0] + N'(1)) : quo[N-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt        <= '0;
      rem        <= '0;
      numer      <= '0;
      quo        <= '0;
      mag_b      <= '0;
      sign_q     <= 1'b0;
      a_neg_q    <= 1'b0;
      dz_q       <= 1'b0;
      o_done     <= 1'b0;
      o_result   <= '0;
      o_ovr      <= 1'b0;
      o_div_zero <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            sign_q  <= i_a[N-1] ^ i_b[N-1];
            a_neg_q <= i_a[N-1];
            mag_b   <= q_abs(i_b);
            dz_q    <= (i_b == '0);
            rem     <= '0;
            numer   <= {q_abs(i_a), {Q{1'b0}}};
            quo     <= '0;
            cnt     <= CNT_W'(NQ);
          end
        end
        CALC: begin
          if (!dz_q) begin
            rem   <= rem_nxt;
            numer <= numer << 1;
            quo   <= {quo[NQ-2:0], q_bit};
            cnt   <= cnt - CNT_W'(1);
          end
        end
        FIN: begin
          o_done     <= 1'b1;
          o_result   <= res_nxt;
          o_ovr      <= ovr_nxt;
          o_div_zero <= dz_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qdiv_iter.sv
// Directed-vector bench for qdiv_iter: results, flags, latency, busy/done
// handshake, ignored restarts and reset in mid-operation.
module tb_qdiv_iter;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_result;
  logic        o_ovr;
  logic        o_div_zero;

  int cmp_count = 0;
  int err_count = 0;

  qdiv_iter dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_a        (i_a),
    .i_b        (i_b),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_result   (o_result),
    .o_ovr      (o_ovr),
    .o_div_zero (o_div_zero)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one division; inj > 0 pulses i_start with other operands mid-run.
  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_res, input logic exp_ovr,
                               input logic exp_dz, input int exp_lat, input int inj);
    int   lat;
    logic busy_ok;
    lat     = 0;
    busy_ok = 1'b1;
    @(negedge i_clk);
    i_a     = a;
    i_b     = b;
    i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge i_clk);
      #1 i_start = 1'b0;
      if (o_done) begin
        lat = k;
        break;
      end
      if (!o_busy) busy_ok = 1'b0;
      if (k == inj) begin
        i_start = 1'b1;
        i_a     = 32'h7FFF_FFFF;
        i_b     = 32'h0000_0001;
      end
    end
    i_start = 1'b0;
    checkOutput({tag, " latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, " busy_during"}, 64'(busy_ok), 64'd1);
    checkOutput({tag, " busy_at_done"}, 64'(o_busy), 64'd0);
    checkOutput({tag, " result"}, 64'(o_result), 64'(exp_res));
    checkOutput({tag, " ovr"}, 64'(o_ovr), 64'(exp_ovr));
    checkOutput({tag, " div_zero"}, 64'(o_div_zero), 64'(exp_dz));
    @(posedge i_clk);
    #1;
    checkOutput({tag, " done_pulse"}, 64'(o_done), 64'd0);
    checkOutput({tag, " hold"}, 64'(o_result), 64'(exp_res));
  endtask

  initial begin
    int done_seen;
    #2;
    checkOutput("rst result", 64'(o_result), 64'd0);
    checkOutput("rst ovr", 64'(o_ovr), 64'd0);
    checkOutput("rst div_zero", 64'(o_div_zero), 64'd0);
    checkOutput("rst done", 64'(o_done), 64'd0);
    checkOutput("rst busy", 64'(o_busy), 64'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;

    applyStimulus("3/1.5",    32'h000C_0000, 32'h0006_0000, 32'h0008_0000, 1'b0, 1'b0, 51, 0);
    applyStimulus("-1/4",     32'hFFFC_0000, 32'h0010_0000, 32'hFFFF_0000, 1'b0, 1'b0, 51, 0);
    applyStimulus("1/-4",     32'h0004_0000, 32'hFFF0_0000, 32'hFFFF_0000, 1'b0, 1'b0, 51, 0);
    applyStimulus("tiny/-2",  32'h0000_0001, 32'hFFF8_0000, 32'h0000_0000, 1'b0, 1'b0, 51, 0);
    applyStimulus("max/lsb",  32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 51, 0);
    applyStimulus("min/lsb",  32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0, 51, 0);
    applyStimulus("zero/0",   32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 2, 0);
    applyStimulus("ignore",   32'h000C_0000, 32'h0006_0000, 32'h0008_0000, 1'b0, 1'b0, 51, 10);
    applyStimulus("-1/0",     32'hFFFC_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1, 2, 0);

    // Reset in the middle of a division, after an ignored restart pulse.
    @(negedge i_clk);
    i_a     = 32'h000C_0000;
    i_b     = 32'h0006_0000;
    i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    repeat (9) @(posedge i_clk);
    #1;
    i_start = 1'b1;
    i_a     = 32'h7FFF_FFFF;
    i_b     = 32'h0000_0001;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    checkOutput("mid busy", 64'(o_busy), 64'd1);
    repeat (9) @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    checkOutput("midrst result", 64'(o_result), 64'd0);
    checkOutput("midrst ovr", 64'(o_ovr), 64'd0);
    checkOutput("midrst div_zero", 64'(o_div_zero), 64'd0);
    checkOutput("midrst busy", 64'(o_busy), 64'd0);
    checkOutput("midrst done", 64'(o_done), 64'd0);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    done_seen = 0;
    repeat (60) begin
      @(posedge i_clk);
      #1;
      if (o_done) done_seen++;
    end
    checkOutput("postrst no_done", 64'(done_seen), 64'd0);
    checkOutput("postrst result", 64'(o_result), 64'd0);

    applyStimulus("fresh", 32'hFFFC_0000, 32'h0010_0000, 32'hFFFF_0000, 1'b0, 1'b0, 51, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
